// File: rtl/txpippm_pkg.sv
// Shared state encoding and stepsize field layout for the TX PI PPM pulse sequencer.
package txpippm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE_HI = 2'd1,
      ST_WAIT     = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam int unsigned STEP_WIDTH     = 5;
   localparam int unsigned STEP_DIR_BIT   = 4;
   localparam int unsigned STEP_MAG_MSB   = 3;
   localparam int unsigned STEP_MAG_LSB   = 0;
   localparam int unsigned STEP_MAG_WIDTH = STEP_MAG_MSB - STEP_MAG_LSB + 1;

   function automatic logic [STEP_MAG_WIDTH-1:0] step_magnitude(input logic [STEP_WIDTH-1:0] s);
      return s[STEP_MAG_MSB:STEP_MAG_LSB];
   endfunction

   function automatic logic step_direction(input logic [STEP_WIDTH-1:0] s);
      return s[STEP_DIR_BIT];
   endfunction

endpackage

// File: rtl/txpippm_pulse_sequencer.sv
// Accepts a drift command and emits a paced train of step pulses with stepsize and
// channel mask held stable for the whole train.
module txpippm_pulse_sequencer
   import txpippm_pkg::*;
#(
   parameter int unsigned CHANNEL_COUNT     = 10,
   parameter int unsigned INTERVAL_WIDTH    = 16,
   parameter int unsigned COUNT_WIDTH       = 16,
   parameter int unsigned PULSE_HIGH_CYCLES = 4,
   parameter int unsigned MIN_INTERVAL      = 8
) (
   input  logic                      gtwiz_userclk_tx_usrclk_in,
   input  logic                      reset_n_in,
   input  logic                      cfg_valid_in,
   output logic                      cfg_ready_out,
   input  logic [INTERVAL_WIDTH-1:0] cfg_interval_in,
   input  logic [COUNT_WIDTH-1:0]    cfg_count_in,
   input  logic [STEP_WIDTH-1:0]     cfg_stepsize_in,
   input  logic [CHANNEL_COUNT-1:0]  cfg_sel_in,
   input  logic                      abort_in,
   output logic                      pulse_out,
   output logic [STEP_WIDTH-1:0]     stepsize_out,
   output logic [CHANNEL_COUNT-1:0]  sel_out,
   output logic                      busy_out,
   output logic                      done_out,
   output logic [COUNT_WIDTH-1:0]    pulse_count_out
);

   // Pulse must be visible downstream and leave at least two low cycles per period.
   if (PULSE_HIGH_CYCLES < 1 || MIN_INTERVAL < PULSE_HIGH_CYCLES + 2) begin : g_bad_params
      $error("txpippm_pulse_sequencer: need PULSE_HIGH_CYCLES >= 1 and MIN_INTERVAL >= PULSE_HIGH_CYCLES+2");
   end

   localparam logic [INTERVAL_WIDTH-1:0] HI_LOAD  = INTERVAL_WIDTH'(PULSE_HIGH_CYCLES - 1);
   localparam logic [INTERVAL_WIDTH-1:0] GAP_SUB  = INTERVAL_WIDTH'(PULSE_HIGH_CYCLES + 1);
   localparam logic [INTERVAL_WIDTH-1:0] MIN_IVAL = INTERVAL_WIDTH'(MIN_INTERVAL);

   state_t                    state, state_nxt;
   logic [INTERVAL_WIDTH-1:0] cnt, cnt_nxt;
   logic [INTERVAL_WIDTH-1:0] interval_lat, interval_nxt;
   logic [COUNT_WIDTH-1:0]    count_lat, count_lat_nxt;
   logic [CHANNEL_COUNT-1:0]  sel_lat, sel_lat_nxt;
   logic [STEP_WIDTH-1:0]     step_nxt;
   logic                      abort_seen, abort_nxt;
   logic [COUNT_WIDTH-1:0]    pcount_nxt, pc_base;
   logic                      count_reached;

   assign count_reached = (count_lat != '0) && (pulse_count_out == count_lat);

   // Next-state, counters and latched command fields.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      interval_nxt  = interval_lat;
      count_lat_nxt = count_lat;
      sel_lat_nxt   = sel_lat;
      step_nxt      = stepsize_out;
      abort_nxt     = abort_seen;
      pc_base       = pulse_count_out;
      pcount_nxt    = pulse_count_out;

      unique case (state)
         ST_IDLE: begin
            if (cfg_valid_in && cfg_ready_out) begin
               interval_nxt  = (cfg_interval_in < MIN_IVAL) ? MIN_IVAL : cfg_interval_in;
               count_lat_nxt = cfg_count_in;
               sel_lat_nxt   = cfg_sel_in;
               step_nxt      = cfg_stepsize_in;
               abort_nxt     = 1'b0;
               pc_base       = '0;
               pcount_nxt    = '0;
               cnt_nxt       = HI_LOAD;
               state_nxt     = (step_magnitude(cfg_stepsize_in) == '0) ? ST_DONE : ST_PULSE_HI;
            end
         end
         ST_PULSE_HI: begin
            abort_nxt = abort_seen | abort_in;
            if (cnt == '0) begin
               if (abort_seen || abort_in || count_reached) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = interval_lat - GAP_SUB;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_WAIT: begin
            abort_nxt = abort_seen | abort_in;
            if (abort_in) begin
               state_nxt = ST_DONE;
            end else if (cnt == '0) begin
               state_nxt = ST_PULSE_HI;
               cnt_nxt   = HI_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DONE: begin
            abort_nxt = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Saturating pulse counter steps once per PULSE_HI entry.
      if (state_nxt == ST_PULSE_HI && state != ST_PULSE_HI && pc_base != '1) begin
         pcount_nxt = pc_base + 1'b1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge gtwiz_userclk_tx_usrclk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         interval_lat    <= '0;
         count_lat       <= '0;
         sel_lat         <= '0;
         abort_seen      <= 1'b0;
         cfg_ready_out   <= 1'b1;
         pulse_out       <= 1'b0;
         stepsize_out    <= '0;
         sel_out         <= '0;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         pulse_count_out <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         interval_lat    <= interval_nxt;
         count_lat       <= count_lat_nxt;
         sel_lat         <= sel_lat_nxt;
         abort_seen      <= abort_nxt;
         cfg_ready_out   <= (state_nxt == ST_IDLE);
         pulse_out       <= (state_nxt == ST_PULSE_HI);
         stepsize_out    <= step_nxt;
         sel_out         <= (state_nxt == ST_PULSE_HI || state_nxt == ST_WAIT) ? sel_lat_nxt : '0;
         busy_out        <= (state_nxt != ST_IDLE);
         done_out        <= (state_nxt == ST_DONE);
         pulse_count_out <= pcount_nxt;
      end
   end

endmodule

// File: tb/tb_txpippm_pulse_sequencer.sv
// Directed bench for txpippm_pulse_sequencer; cycle k means k cycles after the accept edge.
module tb_txpippm_pulse_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_interval;
   logic [15:0] cfg_count;
   logic [4:0]  cfg_step;
   logic [9:0]  cfg_sel;
   logic        abort;
   logic        pulse;
   logic [4:0]  step_o;
   logic [9:0]  sel_o;
   logic        busy;
   logic        done;
   logic [15:0] pcount;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   txpippm_pulse_sequencer dut (
      .gtwiz_userclk_tx_usrclk_in(clk),
      .reset_n_in                (rst_n),
      .cfg_valid_in              (cfg_valid),
      .cfg_ready_out             (cfg_ready),
      .cfg_interval_in           (cfg_interval),
      .cfg_count_in              (cfg_count),
      .cfg_stepsize_in           (cfg_step),
      .cfg_sel_in                (cfg_sel),
      .abort_in                  (abort),
      .pulse_out                 (pulse),
      .stepsize_out              (step_o),
      .sel_out                   (sel_o),
      .busy_out                  (busy),
      .done_out                  (done),
      .pulse_count_out           (pcount)
   );

   // Presents a command for exactly one rising edge (the accept edge).
   task automatic start_train(input logic [15:0] ival, input logic [15:0] cnt,
                              input logic [4:0] st, input logic [9:0] sl);
      @(negedge clk);
      cfg_interval = ival;
      cfg_count    = cnt;
      cfg_step     = st;
      cfg_sel      = sl;
      cfg_valid    = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({cfg_ready, pulse, busy, done} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_flags got=%b exp=1000", {cfg_ready, pulse, busy, done});
      end
      vectors++;
      if ({step_o, sel_o, pcount} !== 31'd0) begin
         miscompares++;
         $display("FAIL reset_data step=%h sel=%h cnt=%0d exp all 0", step_o, sel_o, pcount);
      end
   endtask

   task automatic test_basic_train();
      logic ep, ed, er;
      logic [9:0] es;
      logic [15:0] ec;
      start_train(16'd10, 16'd3, 5'b00011, 10'h005);
      for (int k = 1; k <= 27; k++) begin
         @(negedge clk);
         ep = (k >= 1 && k <= 4) || (k >= 11 && k <= 14) || (k >= 21 && k <= 24);
         ed = (k == 25);
         er = (k >= 26);
         es = (k <= 24) ? 10'h005 : 10'h000;
         ec = (k >= 21) ? 16'd3 : (k >= 11) ? 16'd2 : 16'd1;
         vectors++;
         if ({pulse, done, cfg_ready, busy} !== {ep, ed, er, ~er}) begin
            miscompares++;
            $display("FAIL basic_ctrl k=%0d got p/d/r/b=%b exp=%b", k, {pulse, done, cfg_ready, busy}, {ep, ed, er, ~er});
         end
         vectors++;
         if (sel_o !== es || step_o !== 5'b00011 || pcount !== ec) begin
            miscompares++;
            $display("FAIL basic_data k=%0d got sel=%h step=%h cnt=%0d exp sel=%h step=03 cnt=%0d", k, sel_o, step_o, pcount, es, ec);
         end
      end
   endtask

   task automatic test_clamp();
      logic ep, ed;
      start_train(16'd2, 16'd2, 5'b10001, 10'h3FF);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         ep = (k >= 1 && k <= 4) || (k >= 9 && k <= 12);
         ed = (k == 13);
         vectors++;
         if (pulse !== ep || done !== ed) begin
            miscompares++;
            $display("FAIL clamp k=%0d got p=%b d=%b exp p=%b d=%b", k, pulse, done, ep, ed);
         end
      end
   endtask

   task automatic test_abort_in_pulse();
      logic ep, ed;
      start_train(16'd12, 16'd0, 5'b00001, 10'h155);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         ep = (k <= 4);
         ed = (k == 5);
         vectors++;
         if (pulse !== ep || done !== ed || cfg_ready !== (k >= 6)) begin
            miscompares++;
            $display("FAIL abort_pulse k=%0d got p=%b d=%b r=%b exp p=%b d=%b r=%b", k, pulse, done, cfg_ready, ep, ed, k >= 6);
         end
         if (k == 3) abort = 1'b1;
         if (k == 6) abort = 1'b0;
      end
      vectors++;
      if (pcount !== 16'd1) begin
         miscompares++;
         $display("FAIL abort_pulse_count got=%0d exp=1", pcount);
      end
   endtask

   task automatic test_abort_in_wait();
      logic ep, ed;
      start_train(16'd12, 16'd0, 5'b00010, 10'h0F0);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         ep = (k <= 4);
         ed = (k == 9);
         vectors++;
         if (pulse !== ep || done !== ed) begin
            miscompares++;
            $display("FAIL abort_wait k=%0d got p=%b d=%b exp p=%b d=%b", k, pulse, done, ep, ed);
         end
         if (k == 8) abort = 1'b1;
         if (k == 9) abort = 1'b0;
      end
      vectors++;
      if (pcount !== 16'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_wait_end got cnt=%0d busy=%b exp cnt=1 busy=0", pcount, busy);
      end
   endtask

   task automatic test_abort_and_count();
      start_train(16'd8, 16'd1, 5'b00100, 10'h001);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         vectors++;
         if (done !== (k == 5) || busy !== (k <= 5) || pulse !== (k <= 4)) begin
            miscompares++;
            $display("FAIL abort_count k=%0d got d=%b b=%b p=%b exp d=%b b=%b p=%b", k, done, busy, pulse, k == 5, k <= 5, k <= 4);
         end
         if (k == 2) abort = 1'b1;
         if (k == 8) abort = 1'b0;
      end
   endtask

   task automatic test_busy_ignore();
      logic ep, ed;
      logic [9:0] es;
      start_train(16'd8, 16'd2, 5'b10010, 10'h2AA);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 3) begin
            cfg_valid = 1'b1; cfg_interval = 16'd20; cfg_count = 16'd9;
            cfg_step = 5'b00111; cfg_sel = 10'h111;
         end
         if (k == 6) cfg_valid = 1'b0;
         ep = (k <= 4) || (k >= 9 && k <= 12);
         ed = (k == 13);
         es = (k <= 12) ? 10'h2AA : 10'h000;
         vectors++;
         if (pulse !== ep || done !== ed || sel_o !== es || step_o !== 5'b10010) begin
            miscompares++;
            $display("FAIL busy_ignore k=%0d got p=%b d=%b sel=%h step=%h exp p=%b d=%b sel=%h step=12", k, pulse, done, sel_o, step_o, ep, ed, es);
         end
      end
      vectors++;
      if (pcount !== 16'd2 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_ignore_end got cnt=%0d r=%b b=%b exp cnt=2 r=1 b=0", pcount, cfg_ready, busy);
      end
   endtask

   task automatic test_zero_magnitude();
      start_train(16'd10, 16'd5, 5'b10000, 10'h3C3);
      @(negedge clk);
      vectors++;
      if ({done, busy, pulse, cfg_ready} !== 4'b1100 || sel_o !== 10'h000 || pcount !== 16'd0) begin
         miscompares++;
         $display("FAIL zero_mag_done got d/b/p/r=%b sel=%h cnt=%0d exp 1100 sel=0 cnt=0", {done, busy, pulse, cfg_ready}, sel_o, pcount);
      end
      @(negedge clk);
      vectors++;
      if ({done, busy, cfg_ready} !== 3'b001 || step_o !== 5'b10000) begin
         miscompares++;
         $display("FAIL zero_mag_idle got d/b/r=%b step=%h exp 001 step=10", {done, busy, cfg_ready}, step_o);
      end
   endtask

   task automatic test_reset_mid_train();
      start_train(16'd10, 16'd0, 5'b00011, 10'h00F);
      repeat (2) @(negedge clk);
      vectors++;
      if (pulse !== 1'b1 || sel_o !== 10'h00F) begin
         miscompares++;
         $display("FAIL rst_mid_pre got p=%b sel=%h exp p=1 sel=00f", pulse, sel_o);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (pulse !== 1'b0 || sel_o !== 10'h000 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_async got p=%b sel=%h b=%b exp 0 000 0", pulse, sel_o, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({cfg_ready, done, busy, pulse} !== 4'b1000 || pcount !== 16'd0) begin
         miscompares++;
         $display("FAIL rst_mid_after got r/d/b/p=%b cnt=%0d exp 1000 cnt=0", {cfg_ready, done, busy, pulse}, pcount);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_interval = '0;
      cfg_count = '0;
      cfg_step = '0;
      cfg_sel = '0;
      abort = 1'b0;
      test_reset();
      test_basic_train();
      test_clamp();
      test_abort_in_pulse();
      test_abort_in_wait();
      test_abort_and_count();
      test_busy_ignore();
      test_zero_magnitude();
      test_reset_mid_train();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
